// File: rtl/spi_led_pkg.sv
// spi_led_pkg: shared types and command codes for the SPI frame buffer
package spi_led_pkg;
  typedef enum logic [1:0] {IDLE, CMD, DATA, DISCARD} state_t;
  localparam logic [7:0] CMD_WRITE = 8'h80;
  localparam logic [7:0] CMD_SHOW = 8'h81;
  localparam int LEDS_DEFAULT = 200;
endpackage

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: synchronises the async SPI pins into byte strobes, CS edges and a MISO status bit
module spi_slave_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs_n,
  input  logic [7:0] status,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       miso
);
  logic [2:0] sck_q, cs_q;
  logic [1:0] mosi_q;
  logic [6:0] shift;
  logic [2:0] bit_cnt;
  logic [7:0] miso_sh;
  logic sck_rise, sck_fall, active;
  always_comb begin
    sck_rise = sck_q[1] && !sck_q[2];
    sck_fall = !sck_q[1] && sck_q[2];
    cs_fall = !cs_q[1] && cs_q[2];
    cs_rise = cs_q[1] && !cs_q[2];
    active = !cs_q[1];
    byte_valid = active && sck_rise && bit_cnt == 3'd7;
    byte_data = {shift, mosi_q[1]};
    miso = miso_sh[7];
  end
  // CS history resets low so a select already held at reset release never looks like a fresh fall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_q <= '0;
      cs_q <= '0;
      mosi_q <= '0;
      shift <= '0;
      bit_cnt <= '0;
      miso_sh <= '0;
    end else begin
      sck_q <= {sck_q[1:0], sck};
      cs_q <= {cs_q[1:0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
      if (cs_fall) begin
        bit_cnt <= '0;
        miso_sh <= status;
      end else if (active && sck_rise) begin
        shift <= {shift[5:0], mosi_q[1]};
        bit_cnt <= bit_cnt + 3'd1;
      end else if (active && sck_fall) begin
        miso_sh <= {miso_sh[6:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/spi_frame_buffer.sv
// spi_frame_buffer: SPI-fed double-buffered pixel memory that hands complete frames to the LED driver
module spi_frame_buffer
  import spi_led_pkg::*;
#(
  parameter int LEDS = LEDS_DEFAULT,
  parameter int CLK_HZ = 50_000_000,
  localparam int AW = $clog2(LEDS*3)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_spi_sck,
  input  logic          i_spi_mosi,
  input  logic          i_spi_cs_n,
  output logic          o_spi_miso,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_start,
  input  logic          i_busy,
  output logic          o_overflow,
  output logic [7:0]    o_frame_cnt
);
  localparam int DEPTH = LEDS*3;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  if (CLK_HZ < 8) begin : g_clk_check
    $error("CLK_HZ too low for an SCK of CLK_HZ/8");
  end
  state_t state, state_next;
  logic byte_valid, cs_fall, cs_rise, miso_bit;
  logic [7:0] byte_data;
  logic show, pending_show, front, we, ovf_hit, set_pend, swap;
  logic [1:0] hold;
  logic [AW:0] wr_addr, wr_idx, rd_idx;
  logic [7:0] mem [2*DEPTH];
  spi_slave_rx u_rx (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .sck(i_spi_sck),
    .mosi(i_spi_mosi),
    .cs_n(i_spi_cs_n),
    .status({pending_show, o_overflow, o_frame_cnt[5:0]}),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .cs_fall(cs_fall),
    .cs_rise(cs_rise),
    .miso(miso_bit)
  );
  always_ff @(posedge i_clk) state <= !i_rst_n ? IDLE : state_next;
  always_comb begin
    state_next = cs_rise ? IDLE :
                 cs_fall ? CMD :
                 (state == CMD && byte_valid) ?
                   ((byte_data == CMD_WRITE || byte_data == CMD_SHOW) ? DATA : DISCARD) :
                 state;
  end
  always_comb begin
    we = state == DATA && byte_valid && wr_addr != DEPTH_W;
    ovf_hit = state == DATA && byte_valid && wr_addr == DEPTH_W;
    set_pend = state == DATA && cs_rise && show;
    o_spi_miso = state == CMD && miso_bit;
  end
  // Bank 0 occupies [0, DEPTH), bank 1 [DEPTH, 2*DEPTH); writes use the bank in effect before any swap this cycle
  assign swap = pending_show && !i_busy && hold == 2'd0;
  assign wr_idx = (front ? '0 : DEPTH_W) + wr_addr;
  assign rd_idx = (front ? DEPTH_W : '0) + {1'b0, i_rd_addr};
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_addr <= '0;
      show <= 1'b0;
      pending_show <= 1'b0;
      front <= 1'b0;
      hold <= '0;
      o_start <= 1'b0;
      o_overflow <= 1'b0;
      o_frame_cnt <= '0;
      o_rd_data <= '0;
    end else begin
      if (cs_fall) wr_addr <= '0;
      else if (we) wr_addr <= wr_addr + (AW+1)'(1);
      if (state == CMD && byte_valid) show <= byte_data == CMD_SHOW;
      pending_show <= set_pend || (pending_show && !swap);
      front <= front ^ swap;
      hold <= swap ? 2'd2 : hold - {1'b0, |hold};
      o_start <= swap;
      o_frame_cnt <= o_frame_cnt + {7'd0, swap};
      o_overflow <= o_overflow || ovf_hit;
      o_rd_data <= ({1'b0, i_rd_addr} < DEPTH_W) ? mem[rd_idx] : 8'h00;
    end
  end
  always_ff @(posedge i_clk) if (we) mem[wr_idx] <= byte_data;
endmodule
